bcd_to_binary: RTL and testbench
================================

BCD_TO_BINARY -- requirements
Module: bcd_to_binary

Interface
REQ-001: clock  input  1  single clock; all state updates on its rising edge.
REQ-002: reset  input  1  synchronous, active-high reset.
REQ-003: start  input  1  conversion request, sampled only in IDLE.
REQ-004: bcd  input  12  three packed BCD digits: [11:8] hundreds, [7:4] tens, [3:0] units.
REQ-005: bin  output  8  registered binary result; holds its value until the next DONE.
REQ-006: busy  output  1  high while in SHIFT.
REQ-007: done  output  1  one-cycle pulse when a result is written to bin.
REQ-008: error  output  1  range/validity flag, registered alongside bin.

Function
REQ-009: The FSM SHALL have states IDLE, SHIFT and DONE.
REQ-010: IDLE with start=1 SHALL load bcd into the digit register, clear the 8-bit result shift register, clear the iteration counter, and go to SHIFT.
REQ-011: IDLE with start=0 SHALL remain in IDLE.
REQ-012: Each SHIFT cycle SHALL shift {digit reg, result reg} right by one bit, then subtract 3 from every digit nibble that is >= 8 (reverse double dabble).
REQ-013: SHIFT SHALL perform exactly 8 iterations, with the counter wrapping 0..7, then go to DONE.
REQ-014: On the SHIFT->DONE edge, bin SHALL take the result register, error SHALL take the check result, and done SHALL assert for exactly one cycle.
REQ-015: DONE SHALL return unconditionally to IDLE.
REQ-016: Latency: start sampled at edge N gives done=1 and a valid bin from edge N+8 until edge N+9.
REQ-017: start and bcd changes in SHIFT or DONE SHALL be ignored, with no queueing.
REQ-018: The minimum start-to-start spacing is 10 cycles (load, 8 x SHIFT, DONE).
REQ-019: bin SHALL equal the low 8 bits of the decimal value for valid digits.

Reset
REQ-020: reset=1 SHALL force IDLE at the next edge in any state, including mid-SHIFT, and abandon any partial conversion.
REQ-021: Reset values: bin=0, busy=0, done=0, error=0; internal registers and counter cleared.
REQ-022: reset SHALL take priority over start in the same cycle.

Configuration
REQ-023: The macro BCD_TO_BINARY_RANGE_CHECK_EN compiles in range checking.
REQ-024: With BCD_TO_BINARY_RANGE_CHECK_EN defined, error=1 SHALL be set if any loaded digit is > 9 (captured at load) or the digit register is non-zero after 8 iterations (value > 255). bin still gives the low 8 bits.
REQ-025: Without the macro, the error port SHALL exist but be tied to 0. bin for invalid digits is deterministic but unspecified.

Structure
REQ-026: The shared package bcd_conv_pkg SHALL hold the constants DIGITS=3, BCD_W=12, BIN_W=8, ITERATIONS=8 and the FSM state encoding (IDLE, SHIFT, DONE).
REQ-027: The combinational sub-module bcd_digit_adjust (4-bit in, 4-bit out, subtract 3 if >= 8) SHALL be instantiated once per digit.
REQ-028: The block SHALL contain no other sub-modules.

Verification
REQ-029: reset, then start with bcd=12'h123 -> done pulse at edge N+8, bin=8'h7B, error=0, busy high for 8 cycles.
REQ-030: bcd=12'h255 -> bin=8'hFF, error=0. bcd=12'h000 -> bin=8'h00, error=0.
REQ-031: With the macro: bcd=12'h256 -> bin=8'h00, error=1. bcd=12'h1A0 -> error=1. Without the macro: both cases give error=0.
REQ-032: start 12'h042, then start held high with bcd=12'h099 during SHIFT -> one done pulse with bin=8'h2A; no second conversion until IDLE.
REQ-033: reset asserted at the 4th SHIFT cycle -> next cycle busy=0, done=0, bin=0, and no done pulse follows. A subsequent start with 12'h200 -> bin=8'hC8.
REQ-034: back-to-back starts at exact 10-cycle spacing with 12'h007 then 12'h128 -> bins 8'h07 then 8'h80, two done pulses exactly 10 cycles apart.

Source files
------------

// File: rtl/bcd_conv_pkg.sv
// Shared constants, FSM state encoding and digit-validity helper for the
// three-digit BCD to 8-bit binary converter.
package bcd_conv_pkg;

  localparam int DIGITS     = 3;
  localparam int BCD_W      = 12;
  localparam int BIN_W      = 8;
  localparam int ITERATIONS = 8;
  localparam int CNT_W      = 3;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  function automatic logic any_digit_invalid(input logic [BCD_W-1:0] b);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (b[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// One nibble of the reverse double-dabble correction: a digit that received
// the shifted-in bit (worth 8, really 5) is pulled back down by 3.
module bcd_digit_adjust (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  assign digit_o = (digit_i >= 4'd8) ? (digit_i - 4'd3) : digit_i;

endmodule

// File: rtl/bcd_to_binary.sv
// Serial BCD (3 digits) to 8-bit binary converter, reverse double dabble.
// Define BCD_TO_BINARY_RANGE_CHECK_EN to drive error from digit/overflow checks.
module bcd_to_binary
  import bcd_conv_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [11:0] bcd,
  output logic [7:0]  bin,
  output logic        busy,
  output logic        done,
  output logic        error
);

  logic [1:0]       state_q, state_d;
  logic [BCD_W-1:0] digits_q, digits_d;
  logic [BIN_W-1:0] result_q, result_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic             done_q, done_d;
  logic             error_q, error_d;

  logic [BCD_W+BIN_W-1:0] shifted;
  logic [BCD_W-1:0]       adj_digits;
  logic                   check_err;

  assign shifted = {digits_q, result_q} >> 1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit_i (shifted[BIN_W + 4*g +: 4]),
      .digit_o (adj_digits[4*g +: 4])
    );
  end

`ifdef BCD_TO_BINARY_RANGE_CHECK_EN
  logic inv_q, inv_d;

  always_comb begin
    inv_d = inv_q;
    if (state_q == IDLE && start) inv_d = any_digit_invalid(bcd);
  end

  always_ff @(posedge clock) begin
    if (reset) inv_q <= 1'b0;
    else       inv_q <= inv_d;
  end

  // Leftover digit weight after the final shift means the value exceeded 255.
  assign check_err = inv_q | (adj_digits != '0);
`else
  assign check_err = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    bin_d    = bin_q;
    error_d  = error_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          digits_d = bcd;
          result_d = '0;
          cnt_d    = '0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        digits_d = adj_digits;
        result_d = shifted[BIN_W-1:0];
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(ITERATIONS - 1)) begin
          state_d = DONE;
          bin_d   = shifted[BIN_W-1:0];
          error_d = check_err;
          done_d  = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      digits_q <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      bin_q    <= '0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      digits_q <= digits_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      bin_q    <= bin_d;
      done_q   <= done_d;
      error_q  <= error_d;
    end
  end

  assign bin   = bin_q;
  assign busy  = (state_q == SHIFT);
  assign done  = done_q;
  assign error = error_q;

endmodule

// File: tb/tb_bcd_to_binary.sv
// Scoreboard bench for bcd_to_binary: randomized and directed conversions
// checked against a decimal-arithmetic reference model.
module tb_bcd_to_binary;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [11:0] bcd;
  logic [7:0]  bin;
  logic        busy;
  logic        done;
  logic        error;

  bcd_to_binary dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .bcd   (bcd),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .error (error)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] bin;
    logic       err;
    logic       chk_bin;
    int         start_cyc;
    logic [11:0] src;
  } exp_t;

  exp_t sb[$];
  int   done_cycs[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   busy_run = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [11:0] b, input int sc);
    exp_t e;
    int   h, t, u, value;
    logic valid;
    h = int'(b[11:8]);
    t = int'(b[7:4]);
    u = int'(b[3:0]);
    valid = (h <= 9) && (t <= 9) && (u <= 9);
    value = 100 * h + 10 * t + u;
    e.bin       = 8'(value % 256);
    e.chk_bin   = valid;
`ifdef BCD_TO_BINARY_RANGE_CHECK_EN
    e.err       = !valid || (value > 255);
`else
    e.err       = 1'b0;
`endif
    e.start_cyc = sc;
    e.src       = b;
    return e;
  endfunction

  // Monitor: pops one expectation per done pulse.
  always @(negedge clock) begin
    exp_t e;
    if (reset) busy_run = 0;
    else if (busy) busy_run++;
    if (done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        if (e.chk_bin) check($sformatf("bin[%03h]", e.src), 32'(bin), 32'(e.bin));
        check($sformatf("error[%03h]", e.src), 32'(error), 32'(e.err));
        check($sformatf("latency[%03h]", e.src), 32'(cyc - e.start_cyc), 32'd8);
        check($sformatf("busy_cycles[%03h]", e.src), 32'(busy_run), 32'd8);
        done_cycs.push_back(cyc);
      end
      busy_run = 0;
    end
  end

  task automatic start_conv(input logic [11:0] b, input bit expect_result);
    start = 1'b1;
    bcd   = b;
    @(posedge clock);
    #1;
    if (expect_result) sb.push_back(model(b, cyc));
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (sb.size() != 0 && k < 40) begin
      @(posedge clock);
      k++;
    end
    if (sb.size() != 0) begin
      check("done_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] b;
    int d0;
    reset = 1'b1;
    start = 1'b0;
    bcd   = 12'h000;
    repeat (2) @(posedge clock);
    #1;
    check("reset_bin", 32'(bin), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_error", 32'(error), 32'd0);

    // Reset wins over a simultaneous start.
    start = 1'b1;
    bcd   = 12'h123;
    @(posedge clock);
    #1;
    check("reset_prio_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    start = 1'b0;
    @(posedge clock);
    #1;
    check("idle_no_start_busy", 32'(busy), 32'd0);

    start_conv(12'h123, 1'b1);
    wait_idle();
    start_conv(12'h255, 1'b1);
    wait_idle();
    start_conv(12'h000, 1'b1);
    wait_idle();
    start_conv(12'h256, 1'b1);
    wait_idle();
    start_conv(12'h1A0, 1'b1);
    wait_idle();

    // Start held high with new bcd through SHIFT and DONE: one conversion only.
    start = 1'b1;
    bcd   = 12'h042;
    @(posedge clock);
    #1;
    sb.push_back(model(12'h042, cyc));
    bcd = 12'h099;
    repeat (9) @(posedge clock);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("held_start_no_restart_busy", 32'(busy), 32'd0);
    wait_idle();

    // Abandon a conversion at the 4th SHIFT cycle.
    start_conv(12'h123, 1'b1);
    wait_idle();
    start_conv(12'h999, 1'b0);
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("midshift_reset_busy", 32'(busy), 32'd0);
    check("midshift_reset_done", 32'(done), 32'd0);
    check("midshift_reset_bin", 32'(bin), 32'd0);
    repeat (12) @(posedge clock);
    #1;
    start_conv(12'h200, 1'b1);
    wait_idle();

    // Back-to-back at the minimum 10-cycle spacing.
    done_cycs.delete();
    start_conv(12'h007, 1'b1);
    repeat (9) @(posedge clock);
    #1;
    start_conv(12'h128, 1'b1);
    wait_idle();
    check("b2b_done_count", 32'(done_cycs.size()), 32'd2);
    if (done_cycs.size() == 2)
      check("b2b_done_spacing", 32'(done_cycs[1] - done_cycs[0]), 32'd10);

    for (int i = 0; i < 40; i++) begin
      b = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      if ($urandom_range(0, 7) == 0) begin
        d0 = $urandom_range(0, 2);
        b[4*d0 +: 4] = 4'($urandom_range(10, 15));
      end
      repeat ($urandom_range(0, 2)) @(posedge clock);
      #1;
      start_conv(b, 1'b1);
      wait_idle();
    end

    repeat (4) @(posedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
